fir_mac_filter: RTL and testbench

//  Parametrised time-multiplexed FIR filter: y[n] = sum_{k=0..TAPS-1} c[k]*x[n-k].
//  One shared multiplier and accumulator, one tap per clock.

---
 rtl/fir_mac_filter.sv | 144 ++++++++++++++
 tb/tb_fir_mac_filter.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_filter.sv
// Time-multiplexed FIR filter: y[n] = sum_k c[k]*x[n-k], one tap per clock
// through a single shared multiplier and accumulator.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     sample handshake (ready only while idle), in_data signed
//   coef_we/addr/data     run-time coefficient write, honoured only while idle
//   out_valid/out_ready   result handshake, out_data held until accepted
//   busy                  high while computing or presenting a result
module fir_mac_filter #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned COEF_W = 8,
  parameter int unsigned TAPS   = 4,
  parameter int unsigned OUT_W  = 32,
  parameter int unsigned SAT    = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [DATA_W-1:0]  in_data,
  input  logic                      coef_we,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic signed [COEF_W-1:0]  coef_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [OUT_W-1:0]   out_data,
  output logic                      busy
);

  localparam int unsigned AW    = $clog2(TAPS);
  localparam int unsigned CW    = $clog2(TAPS + 1);
  localparam int unsigned PW    = DATA_W + COEF_W;
  localparam int unsigned ACC_W = PW + AW;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic signed [DATA_W-1:0] x_q [TAPS];
  logic signed [COEF_W-1:0] c_q [TAPS];
  logic signed [ACC_W-1:0]  acc_q;
  logic [CW-1:0]            cnt_q;

  logic accept, coef_wr, acc_en, fin;

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    coef_wr = 1'b0;
    acc_en  = 1'b0;
    fin     = 1'b0;
    case (state_q)
      S_IDLE: begin
        coef_wr = coef_we && (32'(coef_addr) < TAPS);
        if (in_valid) begin
          accept  = 1'b1;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        // Counter runs one past the last tap: that extra cycle registers the sum.
        if (cnt_q == CW'(TAPS)) begin
          fin     = 1'b1;
          state_d = S_OUT;
        end else begin
          acc_en  = 1'b1;
        end
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Shared multiplier: tap index clamps to 0 on the finalise cycle
  logic [AW-1:0]          tap_idx;
  logic signed [PW-1:0]   x_ext, c_ext, prod;

  assign tap_idx = (32'(cnt_q) < TAPS) ? cnt_q[AW-1:0] : '0;
  assign x_ext   = PW'(x_q[tap_idx]);
  assign c_ext   = PW'(c_q[tap_idx]);
  assign prod    = x_ext * c_ext;

  // Final result formatting: sign-extend, saturate or wrap
  logic signed [OUT_W-1:0] res_c;
  generate
    if (OUT_W >= ACC_W) begin : g_ext
      assign res_c = OUT_W'(acc_q);
    end else if (SAT != 0) begin : g_sat
      logic ovf;
      // Overflow whenever the bits dropped differ from the kept sign bit.
      assign ovf   = acc_q[ACC_W-1:OUT_W-1] != {(ACC_W-OUT_W+1){acc_q[ACC_W-1]}};
      assign res_c = !ovf            ? acc_q[OUT_W-1:0]             :
                     acc_q[ACC_W-1]  ? {1'b1, {(OUT_W-1){1'b0}}}    :
                                       {1'b0, {(OUT_W-1){1'b1}}};
    end else begin : g_wrap
      assign res_c = acc_q[OUT_W-1:0];
    end
  endgenerate

  // Delay line, coefficients, accumulator and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < TAPS; i++) begin
        x_q[AW'(i)] <= '0;
        c_q[AW'(i)] <= '0;
      end
      acc_q     <= '0;
      cnt_q     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      if (coef_wr) c_q[coef_addr] <= coef_data;
      if (accept) begin
        for (int unsigned i = 1; i < TAPS; i++) x_q[AW'(i)] <= x_q[AW'(i - 1)];
        x_q[0] <= in_data;
        acc_q  <= '0;
        cnt_q  <= '0;
      end else if (acc_en) begin
        acc_q  <= acc_q + ACC_W'(prod);
        cnt_q  <= cnt_q + CW'(1);
      end
      if (fin) out_data <= res_c;
      out_valid <= (state_d == S_OUT);
      in_ready  <= (state_d == S_IDLE);
      busy      <= (state_d != S_IDLE);
    end
  end

endmodule

// File: tb/tb_fir_mac_filter.sv
// Bench for fir_mac_filter: three instances (32-bit, 8-bit saturating, 8-bit
// wrapping) share one stimulus stream and are compared every cycle against a
// sample-level model of the filter.
module tb_fir_mac_filter;

  localparam int TAPS = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic signed [7:0] in_data;
  logic              coef_we;
  logic [1:0]        coef_addr;
  logic signed [7:0] coef_data;
  logic              out_ready;

  logic               in_ready, out_valid, busy;
  logic signed [31:0] out_data;
  logic               s_in_ready, s_out_valid, s_busy;
  logic signed [7:0]  s_out_data;
  logic               w_in_ready, w_out_valid, w_busy;
  logic signed [7:0]  w_out_data;

  always #5 clk = ~clk;

  fir_mac_filter #(.DATA_W(8), .COEF_W(8), .TAPS(TAPS), .OUT_W(32), .SAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy));

  fir_mac_filter #(.DATA_W(8), .COEF_W(8), .TAPS(TAPS), .OUT_W(8), .SAT(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data), .busy(s_busy));

  fir_mac_filter #(.DATA_W(8), .COEF_W(8), .TAPS(TAPS), .OUT_W(8), .SAT(0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready), .in_data(in_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_data(w_out_data), .busy(w_busy));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat8(input int v);
    if (v > 127)  return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  function automatic int wrap8(input int v);
    logic signed [7:0] t;
    t = v[7:0];
    return int'(t);
  endfunction

  // Sample-level model: a sample accepted while idle produces sum(c*x)
  // TAPS+1 edges later, held until out_ready; coefficient writes only land while idle.
  int  mx [TAPS];
  int  mc [TAPS];
  bit  m_idle  = 1'b1;
  bit  m_valid = 1'b0;
  int  m_wait  = 0;
  int  m_data  = 0;
  bit  chk_en  = 1'b0;
  int  res_q [$];

  task automatic model_step();
    if (!rst_n) begin
      for (int k = 0; k < TAPS; k++) begin
        mx[k] = 0;
        mc[k] = 0;
      end
      m_idle  = 1'b1;
      m_valid = 1'b0;
      m_wait  = 0;
      m_data  = 0;
      chk_en  = 1'b1;
    end else if (m_idle) begin
      if (coef_we) mc[coef_addr] = int'(coef_data);
      if (in_valid) begin
        for (int k = TAPS - 1; k > 0; k--) mx[k] = mx[k-1];
        mx[0]  = int'(in_data);
        m_idle = 1'b0;
        m_wait = TAPS + 1;
      end
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin
        m_data = 0;
        for (int k = 0; k < TAPS; k++) m_data += mc[k] * mx[k];
        m_valid = 1'b1;
      end
    end else if (out_ready) begin
      m_valid = 1'b0;
      m_idle  = 1'b1;
      res_q.push_back(m_data);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Compare all instances against the model every cycle
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("in_ready",    int'(in_ready),    int'(m_idle));
      check("busy",        int'(busy),        int'(!m_idle));
      check("out_valid",   int'(out_valid),   int'(m_valid));
      check("out_data",    int'(out_data),    m_data);
      check("sat_valid",   int'(s_out_valid), int'(m_valid));
      check("sat_data",    int'(s_out_data),  sat8(m_data));
      check("wrap_valid",  int'(w_out_valid), int'(m_valid));
      check("wrap_data",   int'(w_out_data),  wrap8(m_data));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input int v);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'(v);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("send_timeout", n, 0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("idle_timeout", n, 0);
  endtask

  task automatic set_coefs(input int c0, input int c1, input int c2, input int c3);
    int c [TAPS];
    c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
    wait_idle();
    for (int k = 0; k < TAPS; k++) begin
      @(negedge clk);
      coef_we   = 1'b1;
      coef_addr = 2'(k);
      coef_data = 8'(c[k]);
    end
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic pin(input string name, input int idx, input int exp);
    if (idx < res_q.size()) check(name, res_q[idx], exp);
    else check({name, "_missing"}, res_q.size(), idx + 1);
  endtask

  initial begin
    int base;
    int n;
    int exp1 [5];
    int exp2 [3];
    exp1[0] = 1; exp1[1] = 2; exp1[2] = 3; exp1[3] = 4; exp1[4] = 0;
    exp2[0] = 2; exp2[1] = 8; exp2[2] = 22;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_out_data", int'(out_data), 0);
    check("reset_in_ready", int'(in_ready), 1);
    rst_n = 1'b1;

    // Impulse response and latency
    set_coefs(1, 2, 3, 4);
    base = res_q.size();
    send(1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("latency", n, 5);
    for (int i = 0; i < 4; i++) send(0);
    wait_idle();
    for (int i = 0; i < 5; i++) pin("impulse", base + i, exp1[i]);

    // Ramp with new coefficients
    set_coefs(2, 4, 8, 0);
    base = res_q.size();
    send(1); send(2); send(3);
    wait_idle();
    for (int i = 0; i < 3; i++) pin("ramp", base + i, exp2[i]);

    // Output backpressure: result held, second sample waits
    base = res_q.size();
    @(negedge clk);
    out_ready = 1'b0;
    send(1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b1;
    in_data  = 8'sd7;
    repeat (10) @(negedge clk);
    check("hold_in_ready", int'(in_ready), 0);
    check("hold_data", int'(out_data), 30);
    out_ready = 1'b1;
    @(negedge clk);
    check("ready_after_hs", int'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    wait_idle();
    pin("hold_first", base, 30);
    pin("hold_second", base + 1, 42);

    // Saturation / wrap at OUT_W=8
    set_coefs(127, 127, 127, 127);
    base = res_q.size();
    for (int i = 0; i < 4; i++) send(127);
    wait_idle();
    pin("sat_pos_full", base + 3, 64516);
    if (base + 3 < res_q.size()) begin
      check("sat_pos_model", sat8(res_q[base+3]), 127);
      check("wrap_pos_model", wrap8(res_q[base+3]), 4);
    end
    base = res_q.size();
    for (int i = 0; i < 4; i++) send(-128);
    wait_idle();
    pin("sat_neg_full", base + 3, -65024);
    if (base + 3 < res_q.size()) check("sat_neg_model", sat8(res_q[base+3]), -128);

    // Coefficient writes: ignored mid-computation, applied with a same-cycle sample
    set_coefs(1, 2, 3, 4);
    for (int i = 0; i < 4; i++) send(0);
    wait_idle();
    base = res_q.size();
    send(5);
    coef_we = 1'b1; coef_addr = 2'd0; coef_data = 8'sd100;
    @(negedge clk);
    coef_we = 1'b0;
    send(1);
    wait_idle();
    @(negedge clk);
    coef_we = 1'b1; coef_addr = 2'd0; coef_data = 8'sd100;
    in_valid = 1'b1; in_data = 8'sd2;
    @(negedge clk);
    coef_we = 1'b0; in_valid = 1'b0;
    wait_idle();
    pin("coef_mac_ignored", base, 5);
    pin("coef_old_used", base + 1, 11);
    pin("coef_same_cycle", base + 2, 217);

    // Reset in the middle of the accumulation
    set_coefs(1, 2, 3, 4);
    base = res_q.size();
    send(9);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_out_data", int'(out_data), 0);
    check("rst_in_ready", int'(in_ready), 1);
    repeat (8) @(negedge clk);
    check("rst_no_result", res_q.size(), base);
    send(1);
    for (int i = 0; i < 3; i++) send(0);
    wait_idle();
    for (int i = 0; i < 4; i++) pin("rst_impulse", base + i, 0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
